// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM states, fetch-queue entry layout and branch decode helpers.
// Imported by if_stage and fetch_queue.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } fq_entry_t;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // B-type immediate: sign-extended, bit 0 always zero.
    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    // Conditional branch whose offset is negative (sign bit of the immediate set).
    function automatic logic is_back_branch(input logic [31:0] inst);
        return (inst[6:0] == OPC_BRANCH) && inst[31];
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched {pc, inst, pred} entries with whole-queue flush.
// Latency: a pushed entry is at the head the cycle after the push.
// Backpressure: none internally; the producer must not push when count == DEPTH.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  fq_entry_t       push_dat,
    input  logic            pop,
    input  logic            flush,
    output fq_entry_t       head_dat,
    output logic [CW-1:0]   count
);

    localparam int AW = $clog2(DEPTH);

    fq_entry_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    // Popping an empty queue (e.g. straight after a flush) does nothing.
    assign do_pop = pop && (count != '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the consumer qualifies the head with count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    assign head_dat = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, one outstanding imem fetch, queues {pc, inst, pred} for decode (option FETCH_BTFN_EN).
// Latency: request issued the cycle after a slot frees; response pushed on arrival, visible to decode next cycle.
// Backpressure: stops requesting while the fetch queue is full; a redirect squashes in-flight and queued work.
module if_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_pred_taken,
    input  logic        inst_ready
);

    localparam int             CW      = $clog2(FQ_DEPTH) + 1;
    localparam logic [CW-1:0]  FQ_FULL = CW'(FQ_DEPTH);

    fetch_state_e  state;
    logic [31:0]   pc;
    logic [31:0]   req_pc;
    logic [31:0]   redirect_tgt;
    logic          accept;
    logic          push;
    logic          pop;
    logic          push_pred;
    logic          slot_free;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    fq_entry_t     push_dat;
    fq_entry_t     head_dat;
    logic          unused_bits;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};
    assign accept       = imem_req_valid && imem_req_ready;
    assign pop          = inst_valid && inst_ready;
    assign push         = (state == WAIT) && imem_rsp_valid && !redirect_valid;

`ifdef FETCH_BTFN_EN
    assign push_pred   = is_back_branch(imem_rsp_data);
    assign unused_bits = ^redirect_pc[1:0];
`else
    assign push_pred   = 1'b0;
    assign unused_bits = ^{redirect_pc[1:0], head_dat.pred};
`endif

    // Look-ahead occupancy so the request valid can be registered without losing a cycle.
    assign count_nxt = count + CW'(push) - CW'(pop);
    assign slot_free = (count_nxt < FQ_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            req_pc         <= RESET_PC;
            imem_req_valid <= 1'b0;
        end else if (redirect_valid) begin
            pc <= redirect_tgt;
            // A request already accepted (now or earlier) still owes a response that must be eaten.
            if (((state == REQ) && accept) ||
                (((state == WAIT) || (state == DROP)) && !imem_rsp_valid)) begin
                state          <= DROP;
                imem_req_valid <= 1'b0;
            end else begin
                state          <= REQ;
                imem_req_valid <= 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    state          <= REQ;
                    imem_req_valid <= slot_free;
                end
                REQ: begin
                    if (accept) begin
                        req_pc         <= pc;
                        pc             <= pc + 32'd4;
                        state          <= WAIT;
                        imem_req_valid <= 1'b0;
                    end else begin
                        imem_req_valid <= slot_free;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        state          <= REQ;
                        imem_req_valid <= slot_free;
                        if (push_pred) begin
                            pc <= req_pc + b_imm(imem_rsp_data);
                        end
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state          <= REQ;
                        imem_req_valid <= slot_free;
                    end
                end
                default: begin
                    state          <= IDLE;
                    imem_req_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_addr = pc;

    assign push_dat = '{pc: req_pc, inst: imem_rsp_data, pred: push_pred};

    fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (redirect_valid),
        .head_dat (head_dat),
        .count    (count)
    );

    // Head fields read as zero when the queue is empty.
    assign inst_valid = (count != '0);
    assign inst       = inst_valid ? head_dat.inst : 32'd0;
    assign inst_pc    = inst_valid ? head_dat.pc   : 32'd0;

`ifdef FETCH_BTFN_EN
    assign inst_pred_taken = inst_valid && head_dat.pred;
`else
    assign inst_pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus randomized traffic against a transaction-level fetch model.
module tb_if_stage;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_pred_taken;
    logic        inst_ready;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(RPC), .FQ_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .inst_pred_taken (inst_pred_taken),
        .inst_ready      (inst_ready)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    ent_t        mq[$];        // what decode should see, in order
    ent_t        pop_log[$];   // what decode actually took from the DUT
    logic [31:0] acc_log[$];   // addresses the memory accepted
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          out_pend;
    bit          out_squash;
    logic [31:0] out_addr;
    int          rsp_due;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          rand_br = 1'b0;
    bit          just_reset;
    logic [31:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h0000_0013;
            32'h0000_0020: return 32'hFE00_0EE3;
            default: begin
                h = (a ^ 32'h5BD1_E995) * 32'h9E37_79B1;
                h = h ^ (h >> 15);
                h[6:0] = (rand_br && h[3:0] < 4'd4) ? 7'h63 : 7'h13;
                return h;
            end
        endcase
    endfunction

    function automatic bit pred_of(input logic [31:0] w);
`ifdef FETCH_BTFN_EN
        return (w[6:0] == 7'h63) && w[31];
`else
        return (w == 32'hFFFF_FFFF) && (w == 32'h0);
`endif
    endfunction

    function automatic logic [31:0] br_tgt(input logic [31:0] a, input logic [31:0] w);
        int off;
        off = int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) off = off - 4096;
        return a + 32'(off);
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic ent_t pop_at(input int i);
        ent_t e;
        e.pc = 32'hDEAD_BEEF; e.inst = 32'hDEAD_BEEF; e.pred = 1'b1;
        return (i < pop_log.size()) ? pop_log[i] : e;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_vld", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RPC);
        chk("rst_inst_vld", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_pred", 32'(inst_pred_taken), 32'd0);
        rst = 1'b0;
        mq.delete(); pop_log.delete(); acc_log.delete();
        out_pend = 1'b0; out_squash = 1'b0; rsp_due = 0;
        exp_pc = RPC; just_reset = 1'b1;
    endtask

    // One clock: drive inputs at the falling edge, check outputs, advance the model as of the rising edge.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] rpc, input bit irdy);
        bit          rsp_now, acc, do_pop, exp_vld;
        logic [31:0] d;
        ent_t        e;
        rsp_now = out_pend && (rsp_due == 0);
        d = rsp_now ? mem_word(out_addr) : $urandom;
        imem_req_ready = rdy; imem_rsp_valid = rsp_now; imem_rsp_data = d;
        redirect_valid = redir; redirect_pc = rpc; inst_ready = irdy;
        #1;
        exp_vld = !just_reset && !out_pend && (mq.size() < DEPTH);
        chk("req_vld", 32'(imem_req_valid), 32'(exp_vld));
        if (exp_vld) chk("req_addr", imem_req_addr, exp_pc);
        chk("inst_vld", 32'(inst_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("inst_pc", inst_pc, mq[0].pc);
            chk("inst", inst, mq[0].inst);
            chk("pred", 32'(inst_pred_taken), 32'(mq[0].pred));
        end
        acc    = imem_req_valid && rdy;
        do_pop = inst_valid && irdy;
        if (do_pop) begin
            e.pc = inst_pc; e.inst = inst; e.pred = inst_pred_taken;
            pop_log.push_back(e);
            if (!redir && mq.size() != 0) void'(mq.pop_front());
        end
        if (rsp_now) begin
            if (!redir && !out_squash) begin
                e.pc = out_addr; e.inst = d; e.pred = pred_of(d);
                mq.push_back(e);
                if (e.pred) exp_pc = br_tgt(out_addr, d);
            end
            out_pend = 1'b0;
        end
        if (acc) begin
            acc_log.push_back(imem_req_addr);
            out_pend = 1'b1; out_squash = redir; out_addr = imem_req_addr;
            rsp_due = int'($urandom_range(lat_max, lat_min));
            if (!redir) exp_pc = imem_req_addr + 32'd4;
        end
        if (redir) begin
            mq.delete();
            if (out_pend) out_squash = 1'b1;
            exp_pc = rpc & ~32'h3;
        end
        if (out_pend) rsp_due--;
        just_reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Straight-line fetch with decode always ready.
        do_reset();
        lat_min = 1; lat_max = 1;
        repeat (2) step(1, 0, 0, 1);
        chk("t1_no_inst_yet", 32'(inst_valid), 32'd0);
        repeat (4) step(1, 0, 0, 1);
        chk("t1_n_acc", 32'(acc_log.size()), 32'd3);
        chk("t1_addr0", acc_at(0), 32'h0);
        chk("t1_addr1", acc_at(1), 32'h4);
        chk("t1_addr2", acc_at(2), 32'h8);
        chk("t1_n_pop", 32'(pop_log.size()), 32'd2);
        chk("t1_pop0_pc", pop_at(0).pc, 32'h0);
        chk("t1_pop0_inst", pop_at(0).inst, 32'h0050_0093);
        chk("t1_pop1_pc", pop_at(1).pc, 32'h4);
        chk("t1_pop1_inst", pop_at(1).inst, 32'h0000_0013);

        // Decode stalled: queue fills, requests stop, one pop reopens a slot.
        do_reset();
        repeat (12) step(1, 0, 0, 0);
        chk("t2_n_acc", 32'(acc_log.size()), 32'd4);
        chk("t2_last_addr", acc_at(3), 32'hC);
        chk("t2_req_stopped", 32'(imem_req_valid), 32'd0);
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        chk("t2_n_acc_after_pop", 32'(acc_log.size()), 32'd5);
        chk("t2_addr_after_pop", acc_at(4), 32'h10);

        // Redirect while waiting on a slow response.
        do_reset();
        repeat (5) step(1, 0, 0, 0);
        lat_min = 3; lat_max = 3;
        step(1, 0, 0, 0);
        step(1, 1, 32'h103, 0);
        chk("t3_flushed", 32'(inst_valid), 32'd0);
        lat_min = 1; lat_max = 1;
        repeat (4) step(1, 0, 0, 0);
        chk("t3_n_acc", 32'(acc_log.size()), 32'd4);
        chk("t3_redir_addr", acc_at(3), 32'h100);
        chk("t3_head_vld", 32'(inst_valid), 32'd1);
        chk("t3_head_pc", inst_pc, 32'h100);

        // Redirect in the same cycle as the response.
        do_reset();
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 32'h200, 0);
        chk("t4_not_pushed", 32'(inst_valid), 32'd0);
        step(1, 0, 0, 0);
        chk("t4_n_acc", 32'(acc_log.size()), 32'd2);
        chk("t4_redir_addr", acc_at(1), 32'h200);

        // PC wraps past the top of the address space.
        do_reset();
        step(1, 1, 32'hFFFF_FFFC, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("t5_addr_top", acc_at(0), 32'hFFFF_FFFC);
        chk("t5_addr_wrap", acc_at(1), 32'h0);

        // Backward branch at 0x20.
        do_reset();
        step(1, 1, 32'h20, 0);
        repeat (3) step(1, 0, 0, 0);
        chk("t6_br_pc", inst_pc, 32'h20);
        chk("t6_br_inst", inst, 32'hFE00_0EE3);
`ifdef FETCH_BTFN_EN
        chk("t6_pred", 32'(inst_pred_taken), 32'd1);
        chk("t6_next_addr", acc_at(1), 32'h1C);
`else
        chk("t6_pred", 32'(inst_pred_taken), 32'd0);
        chk("t6_next_addr", acc_at(1), 32'h24);
`endif

        // Randomized traffic: varying memory readiness, latency, redirects and decode stalls.
        for (int ph = 0; ph < 3; ph++) begin
            do_reset();
            rand_br = 1'b1;
            lat_min = 1; lat_max = 4;
            for (int i = 0; i < 3000; i++) begin
                step($urandom_range(99, 0) < 70,
                     $urandom_range(99, 0) < 3,
                     $urandom,
                     $urandom_range(99, 0) < (ph == 0 ? 95 : (ph == 1 ? 50 : 15)));
            end
            rand_br = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
